// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan path: FSM encoding, inactive levels, nibble width.
// Combinational helpers only; no state.
package seg7_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  // Common-anode display: anodes and dp segment are active-low.
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_OFF = 1'b1;

  localparam int DIG_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot/digit timebase: slot counter wrapping every SLOT_CYC cycles, digit index wrapping every frame.
// Strobes are combinational and describe what the next clock edge does; no backpressure.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [idx_w(N_DIGITS)-1:0]   idx,
  output logic [idx_w(N_DIGITS)-1:0]   next_idx,
  output logic                         slot_start,
  output logic                         drive_start,
  output logic                         frame_wrap
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = idx_w(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] CNT_DRV  = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0] cnt;

  // Strobes fire one cycle early so the outputs they load are registered on the boundary itself.
  assign slot_start  = (cnt == CNT_LAST);
  assign drive_start = (cnt == CNT_DRV);
  assign frame_wrap  = slot_start && (idx == IDX_LAST);
  assign next_idx    = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_start) begin
      cnt <= '0;
      idx <= next_idx;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Scans an N-digit hex value onto a shared 7-seg decoder with blanking, tear-free frame updates and zero suppression.
// Outputs registered; load is always accepted, new values show from the next frame boundary.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIG_W*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]         dp_in,
  input  logic                        load,
  input  logic                        blank_lz,
  output logic [DIG_W-1:0]            X,
  output logic [N_DIGITS-1:0]         an,
  output logic                        dp,
  output logic                        frame_done
);

  localparam int IW = idx_w(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

  logic [IW-1:0]               idx, next_idx;
  logic                        slot_start, drive_start, frame_wrap;
  logic [0:0]                  state;
  logic [DIG_W*N_DIGITS-1:0]   pend_val, act_val, act_val_nxt;
  logic [N_DIGITS-1:0]         pend_dp, act_dp, act_dp_nxt;
  logic                        pend_valid;
  logic [N_DIGITS-1:0]         supp;
  logic                        hi_zero;

  seg7_slot_timer #(
    .N_DIGITS (N_DIGITS),
    .SLOT_CYC (SLOT_CYC),
    .BLANK_CYC(BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .next_idx   (next_idx),
    .slot_start (slot_start),
    .drive_start(drive_start),
    .frame_wrap (frame_wrap)
  );

  assign frame_done = frame_wrap & ~rst;

  // A load landing on the boundary bypasses pending so it is not delayed a whole frame.
  always_comb begin
    act_val_nxt = act_val;
    act_dp_nxt  = act_dp;
    if (frame_wrap) begin
      if (load) begin
        act_val_nxt = value;
        act_dp_nxt  = dp_in;
      end else if (pend_valid) begin
        act_val_nxt = pend_val;
        act_dp_nxt  = pend_dp;
      end
    end
  end

  always_comb begin
    hi_zero = 1'b1;
    supp    = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      hi_zero = hi_zero & (act_val[i*DIG_W +: DIG_W] == '0);
      supp[i] = blank_lz & hi_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      state      <= ST_BLANK;
      X          <= '0;
      an         <= {N_DIGITS{AN_OFF}};
      dp         <= DP_OFF;
    end else begin
      act_val <= act_val_nxt;
      act_dp  <= act_dp_nxt;
      if (frame_wrap) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end

      // Digit data changes while anodes are dark so the decoder settles before the digit lights.
      if (slot_start) begin
        state <= ST_BLANK;
        an    <= {N_DIGITS{AN_OFF}};
        X     <= act_val_nxt[next_idx*DIG_W +: DIG_W];
        dp    <= ~act_dp_nxt[next_idx];
      end else if (drive_start && state == ST_BLANK) begin
        state <= ST_DRIVE;
        if (supp[idx]) begin
          an <= {N_DIGITS{AN_OFF}};
          dp <= DP_OFF;
        end else begin
          an <= ~(AN_ONE << idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with a time-position reference model and literal spot checks.
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int BC = 2;
  localparam int FR = ND * SC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  X;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_mux #(.N_DIGITS(ND), .SLOT_CYC(SC), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .X(X), .an(an), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: position within the frame since reset, plus displayed/pending values.
  int          pos = 0;
  bit          model_on = 0;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_adp, m_pdp;
  bit          m_pv, m_lz;

  always @(posedge clk) begin
    if (rst) begin
      pos = 0; m_act = '0; m_adp = '0; m_pend = '0; m_pdp = '0;
      m_pv = 0; m_lz = 0; model_on = 1;
    end else if (model_on) begin
      if (pos % FR == FR - 1) begin
        if (load) begin m_act = value; m_adp = dp_in; end
        else if (m_pv) begin m_act = m_pend; m_adp = m_pdp; end
        m_pv = 0;
      end else if (load) begin
        m_pend = value; m_pdp = dp_in; m_pv = 1;
      end
      pos = pos + 1;
      if (pos % SC == BC) m_lz = blank_lz;
    end
  end

  int         c_slot, c_off;
  bit         c_supp;
  logic [3:0] e_an;
  logic       e_dp, e_fd;

  always @(negedge clk) begin
    #1;
    if (model_on) begin
      c_slot = (pos / SC) % ND;
      c_off  = pos % SC;
      c_supp = 0;
      if (c_slot > 0 && m_lz) begin
        c_supp = 1;
        for (int j = c_slot; j < ND; j++)
          if (m_act[j*4 +: 4] != 4'h0) c_supp = 0;
      end
      e_an = (c_off < BC || c_supp) ? 4'hF : ~(4'b0001 << c_slot);
      e_dp = (c_off >= BC && c_supp) ? 1'b1 : ~m_adp[c_slot];
      e_fd = !rst && (pos % FR == FR - 1);
      chk("model_X", 16'(X), 16'(m_act[c_slot*4 +: 4]));
      chk("model_an", 16'(an), 16'(e_an));
      chk("model_dp", 16'(dp), 16'(e_dp));
      chk("model_fd", 16'(frame_done), 16'(e_fd));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    int k = 0;
    while (!frame_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!frame_done) chk("frame_done_timeout", 16'(k), 16'd0);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic lit(input string name, input logic [3:0] ea, input logic [3:0] ex);
    chk({name, "_an"}, 16'(an), 16'(ea));
    chk({name, "_X"}, 16'(X), 16'(ex));
  endtask

  initial begin
    int n;
    // Reset values and first lit digit.
    step(3);
    lit("reset", 4'hF, 4'h0);
    chk("reset_dp", 16'(dp), 16'd1);
    chk("reset_fd", 16'(frame_done), 16'd0);
    rst = 1'b0;
    step(1); chk("rel1_an", 16'(an), 16'hF);
    step(1); chk("rel2_an", 16'(an), 16'hE);

    // Basic scan order and frame period.
    pulse_load(16'h1A2F, 4'h0);
    wait_fd();
    step(1); lit("scan_blank0", 4'hF, 4'hF);
    step(2); lit("scan_d0", 4'hE, 4'hF);
    chk("scan_dp", 16'(dp), 16'd1);
    step(8); lit("scan_d1", 4'hD, 4'h2);
    step(8); lit("scan_d2", 4'hB, 4'hA);
    step(8); lit("scan_d3", 4'h7, 4'h1);
    wait_fd();
    n = 0;
    do begin step(1); n++; end while (!frame_done && n < 100);
    chk("frame_period", 16'(n), 16'd32);

    // Mid-frame load must not tear the current frame.
    step(1);
    pulse_load(16'hABCD, 4'h0);
    wait_fd();
    step(13); lit("tear_d1", 4'hD, 4'hC);
    pulse_load(16'h1234, 4'h0);
    step(5); lit("tear_d2", 4'hB, 4'hB);
    step(8); lit("tear_d3", 4'h7, 4'hA);
    wait_fd();
    step(3); lit("tear_new", 4'hE, 4'h4);

    // Load on the boundary cycle takes effect immediately.
    wait_fd();
    pulse_load(16'h0F00, 4'h0);
    lit("coin_blank0", 4'hF, 4'h0);
    step(2); lit("coin_d0", 4'hE, 4'h0);
    step(16); lit("coin_d2", 4'hB, 4'hF);

    // Leading-zero suppression.
    blank_lz = 1'b1;
    pulse_load(16'h0005, 4'h0);
    wait_fd();
    step(3); lit("lz_d0", 4'hE, 4'h5);
    step(8); chk("lz_d1_an", 16'(an), 16'hF);
    step(16); chk("lz_d3_an", 16'(an), 16'hF);
    pulse_load(16'h0000, 4'h0);
    wait_fd();
    step(3); lit("lz_zero_d0", 4'hE, 4'h0);
    step(8); chk("lz_zero_d1_an", 16'(an), 16'hF);
    blank_lz = 1'b0;
    step(8); lit("lz_off_d2", 4'hB, 4'h0);

    // Decimal point and reset in the middle of a drive phase.
    pulse_load(16'h4321, 4'b0100);
    wait_fd();
    step(3); chk("dp_d0", 16'(dp), 16'd1);
    step(16); lit("dp_d2", 4'hB, 4'h3);
    chk("dp_d2_dp", 16'(dp), 16'd0);
    rst = 1'b1; dp_in = '0;
    step(1); lit("midrst", 4'hF, 4'h0);
    chk("midrst_dp", 16'(dp), 16'd1);
    rst = 1'b0;
    step(2); lit("midrst_d0", 4'hE, 4'h0);
    step(16); lit("midrst_d2", 4'hB, 4'h0);
    chk("midrst_d2_dp", 16'(dp), 16'd1);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
